// File: rtl/master_spi_if.sv
// Request/response handshake and SPI pin bundle for master_spi.
interface master_spi_if #(
  parameter int DWIDTH = 32,
  parameter int ALINES = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ALINES-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              busy;
  logic              spi_clk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;

  // SPI master side (the design)
  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, spi_miso,
    output req_ready, rsp_valid, rsp_rdata, busy, spi_clk, spi_cs_n, spi_mosi
  );

  // Requester / SPI slave side
  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, spi_miso,
    input  req_ready, rsp_valid, rsp_rdata, busy, spi_clk, spi_cs_n, spi_mosi
  );
endinterface

// File: rtl/master_spi.sv
// SPI master, mode 0, MSB first. One register access per chip-select frame:
// {wr, addr, wdata-or-zero} shifted out, last DWIDTH MISO samples returned.
module master_spi #(
  parameter int DWIDTH   = 32,
  parameter int ALINES   = 7,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic         clk,
  input  logic         rst,
  master_spi_if.master bus
);
  localparam int FB     = 1 + ALINES + DWIDTH;
  localparam int CMAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CMAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int BW     = $clog2(FB);

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t            state_q;
  logic [FB-1:0]     shift_q;
  logic [DWIDTH-1:0] rx_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bit_q;
  logic              wr_q;
  logic              sclk_q;
  logic              cs_n_q;
  logic              mosi_q;
  logic              rsp_valid_q;
  logic [DWIDTH-1:0] rsp_rdata_q;
  logic              busy_q;
  logic              idle_q;

  logic [FB-1:0]     frame_d;
  logic [DWIDTH-1:0] rx_d;

  // Frame image of the incoming request and the MISO-shifted read register
  always_comb begin
    frame_d = {bus.req_wr, bus.req_addr, bus.req_wr ? bus.req_wdata : {DWIDTH{1'b0}}};
    rx_d    = {rx_q[DWIDTH-2:0], bus.spi_miso};
  end

  // Frame sequencer with registered SPI pins and response outputs.
  // The high/low phase is tracked by sclk_q itself; every sample shifts into
  // rx_q so only the final DWIDTH samples survive to the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      wr_q        <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            state_q <= S_SETUP;
            shift_q <= frame_d;
            wr_q    <= bus.req_wr;
            rx_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            cs_n_q  <= 1'b0;
            mosi_q  <= frame_d[FB-1];
            busy_q  <= 1'b1;
            idle_q  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_q <= S_SHIFT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt_q != HALF_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              rx_q   <= rx_d;
              if (bit_q == BIT_LAST) begin
                state_q <= S_HOLD;
              end else begin
                bit_q   <= bit_q + 1'b1;
                shift_q <= {shift_q[FB-2:0], 1'b0};
                mosi_q  <= shift_q[FB-2];
              end
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q     <= S_GAP;
            cnt_q       <= '0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= wr_q ? {DWIDTH{1'b0}} : rx_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            idle_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = idle_q & ~rst;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.spi_clk   = sclk_q;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_mosi  = mosi_q;
endmodule

// File: tb/tb_master_spi.sv
// Bench for master_spi: a register-bank SPI slave model on a default-timing
// instance, and a phase-sensitive MISO driver on a fast-divider instance.
module tb_master_spi;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int FB = 1 + AW + DW;

  localparam int C0 = 4, SU0 = 2, HO0 = 2, GA0 = 4;
  localparam int C1 = 2, SU1 = 1, HO1 = 1, GA1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  master_spi_if #(.DWIDTH(DW), .ALINES(AW)) b0 ();
  master_spi_if #(.DWIDTH(DW), .ALINES(AW)) b1 ();

  master_spi #(.DWIDTH(DW), .ALINES(AW), .CLK_DIV(C0), .CS_SETUP(SU0),
               .CS_HOLD(HO0), .CS_GAP(GA0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  master_spi #(.DWIDTH(DW), .ALINES(AW), .CLK_DIV(C1), .CS_SETUP(SU1),
               .CS_HOLD(HO1), .CS_GAP(GA1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Register bank behind the slave, and the bench's own expectation of it
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];

  // Mode-0 slave on b0: capture MOSI on rise, commit complete write frames on CS rise
  logic [FB-1:0] s_bits = '0;
  int unsigned   s_cnt  = 0;
  logic [DW-1:0] s_out  = '0;
  always @(posedge b0.spi_clk or posedge b0.spi_cs_n) begin
    if (b0.spi_cs_n) begin
      if (s_cnt == FB && s_bits[FB-1]) mem[s_bits[FB-2 -: AW]] = s_bits[DW-1:0];
      s_cnt = 0;
    end else begin
      s_bits = {s_bits[FB-2:0], b0.spi_mosi};
      s_cnt++;
    end
  end
  // Slave drives read data MSB first, changing on each falling edge after the address
  always @(negedge b0.spi_clk or negedge b0.spi_cs_n) begin
    if (!b0.spi_cs_n && s_cnt >= 1 + AW && s_cnt < FB) begin
      if (s_cnt == 1 + AW) s_out = mem[s_bits[AW-1:0]];
      else                 s_out = {s_out[DW-2:0], 1'b0};
      b0.spi_miso = s_out[DW-1];
    end else begin
      b0.spi_miso = 1'($urandom);
    end
  end

  // Fast instance: data bit is correct only in the last high cycle, inverted in
  // the first high cycle, random while low
  logic [DW-1:0] g_data  = '0;
  int unsigned   g_rises = 0;
  logic          g_prev  = 1'b0;
  logic          g_bit;
  always @(negedge clk) begin
    if (b1.spi_cs_n) begin
      g_rises     = 0;
      g_prev      = 1'b0;
      b1.spi_miso = 1'($urandom);
    end else begin
      if (b1.spi_clk && !g_prev) g_rises++;
      if (b1.spi_clk && g_rises >= 2 + AW) begin
        g_bit       = g_data[DW - 1 - int'(g_rises - 2 - AW)];
        b1.spi_miso = g_prev ? g_bit : ~g_bit;
      end else begin
        b1.spi_miso = 1'($urandom);
      end
      g_prev = b1.spi_clk;
    end
  end

  function automatic logic [DW+5:0] snap(input int sel);
    if (sel == 0)
      return {b0.spi_cs_n, b0.spi_clk, b0.spi_mosi, b0.rsp_valid, b0.busy, b0.req_ready, b0.rsp_rdata};
    return {b1.spi_cs_n, b1.spi_clk, b1.spi_mosi, b1.rsp_valid, b1.busy, b1.req_ready, b1.rsp_rdata};
  endfunction

  task automatic drive(input int sel, input logic v, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (sel == 0) begin
      b0.req_valid = v; b0.req_wr = w; b0.req_addr = a; b0.req_wdata = d;
    end else begin
      b1.req_valid = v; b1.req_wr = w; b1.req_addr = a; b1.req_wdata = d;
    end
  endtask

  // One request from acceptance through the gap back to idle; the expected
  // waveform is derived from the frame timing rules cycle by cycle.
  task automatic do_frame(input int sel, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic chain, input logic nwr,
                          input logic [AW-1:0] naddr, input logic [DW-1:0] nwdata,
                          input string tag);
    int c, su, ho, ga, n, t, u, k, bad, rd_bad, rises;
    logic [FB-1:0] frame;
    logic [DW-1:0] exp_rd, rd_got;
    logic e_cs, e_sclk, e_mosi, e_mchk, e_rsp, e_busy, e_rdy;
    logic a_cs, a_sclk, a_mosi, a_rsp, a_busy, a_rdy, prev;
    logic [DW-1:0] a_rd;
    string first;
    c  = (sel == 0) ? C0 : C1;
    su = (sel == 0) ? SU0 : SU1;
    ho = (sel == 0) ? HO0 : HO1;
    ga = (sel == 0) ? GA0 : GA1;
    frame  = {wr, addr, wr ? wdata : {DW{1'b0}}};
    exp_rd = wr ? {DW{1'b0}} : ((sel == 0) ? exp_mem[addr] : g_data);
    drive(sel, 1'b1, wr, addr, wdata);
    t = 0;
    while (snap(sel)[DW] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (snap(sel)[DW] !== 1'b1) begin
      failures++;
      $display("FAIL %s accept: req_ready=%b after %0d cycles, required 1", tag, snap(sel)[DW], t);
      drive(sel, 1'b0, 1'b0, '0, '0);
      return;
    end
    @(negedge clk);
    if (chain) drive(sel, 1'b1, nwr, naddr, nwdata);
    else       drive(sel, 1'b0, 1'($urandom), AW'($urandom), $urandom);
    if (wr && sel == 0) exp_mem[addr] = wdata;
    n = 1 + su + 2 * c * FB + ho;
    bad = 0; rd_bad = 0; rises = 0; prev = 1'b0; rd_got = '0; first = "";
    for (t = 1; t <= n + ga; t++) begin
      e_cs = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0; e_mchk = 1'b1; e_rsp = 1'b0;
      e_busy = (t < n + ga);
      e_rdy  = ~e_busy;
      if (t <= su) begin
        e_mosi = frame[FB-1];
      end else if (t <= su + 2 * c * FB) begin
        u = t - su - 1;
        k = u / (2 * c);
        e_sclk = ((u % (2 * c)) >= c);
        e_mosi = frame[FB-1-k];
      end else if (t < n) begin
        e_mchk = 1'b0;
      end else begin
        e_cs  = 1'b1;
        e_rsp = (t == n);
      end
      {a_cs, a_sclk, a_mosi, a_rsp, a_busy, a_rdy, a_rd} = snap(sel);
      if (a_sclk && !prev) rises++;
      prev = a_sclk;
      if (a_cs !== e_cs || a_sclk !== e_sclk || (e_mchk && a_mosi !== e_mosi) ||
          a_rsp !== e_rsp || a_busy !== e_busy || a_rdy !== e_rdy) begin
        if (bad == 0)
          first = $sformatf("cycle %0d got cs=%b sclk=%b mosi=%b rsp=%b busy=%b rdy=%b, required cs=%b sclk=%b mosi=%b rsp=%b busy=%b rdy=%b",
                            t, a_cs, a_sclk, a_mosi, a_rsp, a_busy, a_rdy,
                            e_cs, e_sclk, e_mosi, e_rsp, e_busy, e_rdy);
        bad++;
      end
      if (t >= n && a_rd !== exp_rd) begin
        if (rd_bad == 0) rd_got = a_rd;
        rd_bad++;
      end
      if (t < n + ga) @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s wave: %0d bad cycles, first %s", tag, bad, first);
    end
    checks++;
    if (rd_bad != 0) begin
      failures++;
      $display("FAIL %s rdata: got %h, required %h", tag, rd_got, exp_rd);
    end
    checks++;
    if (rises != FB) begin
      failures++;
      $display("FAIL %s rises: got %0d spi_clk rises, required %0d", tag, rises, FB);
    end
  endtask

  task automatic test_reset();
    logic a_cs, a_sclk, a_mosi, a_rsp, a_busy, a_rdy;
    logic [DW-1:0] a_rd;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    for (int unsigned s = 0; s < 2; s++) begin
      {a_cs, a_sclk, a_mosi, a_rsp, a_busy, a_rdy, a_rd} = snap(int'(s));
      checks++;
      if (a_cs !== 1'b1 || a_sclk !== 1'b0 || a_mosi !== 1'b0 || a_rsp !== 1'b0 ||
          a_busy !== 1'b0 || a_rdy !== 1'b0 || a_rd !== '0) begin
        failures++;
        $display("FAIL reset_state dut%0d: got cs=%b sclk=%b mosi=%b rsp=%b busy=%b rdy=%b rd=%h, required 1 0 0 0 0 0 0",
                 s, a_cs, a_sclk, a_mosi, a_rsp, a_busy, a_rdy, a_rd);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int unsigned s = 0; s < 2; s++) begin
      checks++;
      if (snap(int'(s))[DW] !== 1'b1) begin
        failures++;
        $display("FAIL reset_release dut%0d: req_ready=%b, required 1", s, snap(int'(s))[DW]);
      end
    end
  endtask

  task automatic test_write();
    do_frame(0, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, "write_05");
    checks++;
    if (mem[5] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_05 slave_decode: slave register=%h, required deadbeef", mem[5]);
    end
  endtask

  task automatic test_read();
    do_frame(0, 1'b0, 7'h00, $urandom, 1'b0, 1'b0, '0, '0, "read_00");
  endtask

  task automatic test_loopback();
    logic          w;
    logic [AW-1:0] a;
    do_frame(0, 1'b1, 7'h10, 32'hA5A5_0F0F, 1'b0, 1'b0, '0, '0, "lb_write_10");
    do_frame(0, 1'b0, 7'h10, $urandom, 1'b0, 1'b0, '0, '0, "lb_read_10");
    do_frame(0, 1'b0, 7'h00, $urandom, 1'b0, 1'b0, '0, '0, "lb_read_00");
    for (int unsigned i = 0; i < 6; i++) begin
      w = 1'($urandom);
      a = AW'($urandom_range((1 << AW) - 1, 1));
      do_frame(0, w, a, $urandom, 1'b0, 1'b0, '0, '0, $sformatf("lb_rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0;
    a0 = AW'($urandom_range((1 << AW) - 1, 1));
    a1 = AW'($urandom_range((1 << AW) - 1, 1));
    d0 = $urandom;
    do_frame(0, 1'b1, a0, d0, 1'b1, 1'b0, a0, $urandom, "b2b_0");
    do_frame(0, 1'b0, a0, b0.req_wdata, 1'b1, 1'b1, a1, $urandom, "b2b_1");
    do_frame(0, 1'b1, a1, b0.req_wdata, 1'b0, 1'b0, '0, '0, "b2b_2");
  endtask

  task automatic test_reset_midframe();
    logic [AW-1:0] a;
    int t, bad;
    logic a_cs, a_sclk, a_mosi, a_rsp, a_busy, a_rdy;
    logic [DW-1:0] a_rd;
    a = 7'h2A;
    drive(0, 1'b1, 1'b1, a, ~exp_mem[a]);
    t = 0;
    while (b0.req_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    // cycle 1 + SU0 + 20*2*C0 starts bit 20; land mid high phase
    repeat (SU0 + 20 * 2 * C0 + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    {a_cs, a_sclk, a_mosi, a_rsp, a_busy, a_rdy, a_rd} = snap(0);
    checks++;
    if (a_cs !== 1'b1 || a_sclk !== 1'b0 || a_mosi !== 1'b0 || a_rsp !== 1'b0 ||
        a_busy !== 1'b0 || a_rdy !== 1'b0 || a_rd !== '0) begin
      failures++;
      $display("FAIL abort_state: got cs=%b sclk=%b mosi=%b rsp=%b busy=%b rdy=%b rd=%h, required 1 0 0 0 0 0 0",
               a_cs, a_sclk, a_mosi, a_rsp, a_busy, a_rdy, a_rd);
    end
    rst = 1'b0;
    bad = 0;
    for (int unsigned i = 0; i < 400; i++) begin
      @(negedge clk);
      {a_cs, a_sclk, a_mosi, a_rsp, a_busy, a_rdy, a_rd} = snap(0);
      if (a_rsp !== 1'b0 || a_cs !== 1'b1 || a_sclk !== 1'b0 || a_busy !== 1'b0 || a_rdy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d active cycles after abort, required 0", bad);
    end
    do_frame(0, 1'b0, a, $urandom, 1'b0, 1'b0, '0, '0, "abort_read_old");
    do_frame(0, 1'b1, a, $urandom, 1'b0, 1'b0, '0, '0, "abort_write");
    do_frame(0, 1'b0, a, $urandom, 1'b0, 1'b0, '0, '0, "abort_read_new");
  endtask

  task automatic test_fast_divider();
    for (int unsigned i = 0; i < 4; i++) begin
      g_data = $urandom;
      do_frame(1, 1'($urandom), AW'($urandom), $urandom, 1'b0, 1'b0, '0, '0,
               $sformatf("fast%0d", i));
    end
    g_data = $urandom;
    do_frame(1, 1'b0, AW'($urandom), $urandom, 1'b1, 1'b0, 7'h33, $urandom, "fast_b2b0");
    g_data = $urandom;
    do_frame(1, 1'b0, 7'h33, b1.req_wdata, 1'b0, 1'b0, '0, '0, "fast_b2b1");
  endtask

  initial begin
    for (int unsigned i = 0; i < (1 << AW); i++) begin
      mem[i]     = $urandom;
      exp_mem[i] = mem[i];
    end
    mem[0]     = 32'h0000_0001;
    exp_mem[0] = 32'h0000_0001;
    test_reset();
    test_write();
    test_read();
    test_loopback();
    test_back_to_back();
    test_reset_midframe();
    test_fast_divider();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
